data_mem_wide: RTL and testbench
================================

Name: data_mem_wide

Overview:
Parametrised single-port data memory for the pipelined processor's MEM stage. Successor to the fixed 16-bit, 8-entry data memory, with these additions:
- configurable width and depth
- a registered read with a valid strobe
- two-beat wide (2×DATA_W) accesses for PC/flag push/pop, with a busy stall to the pipeline
- out-of-range address detection

Parameters:
DATA_W, 16, word width in bits
ADDR_W, 11, address width
DEPTH, 2048, number of words; must be ≤ 2^ADDR_W (need not be a power of two)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  access request; sampled only when busy=0
req_we  input  1  1=write, 0=read
req_wide  input  1  1=two-word access, 0=single word
req_addr  input  ADDR_W  word address
req_wdata  input  2*DATA_W  write data; narrow writes use [DATA_W-1:0]
busy  output  1  high while a wide access occupies its second beat; pipeline stalls MEM
rd_valid  output  1  one-cycle pulse: rd_data updated this cycle
rd_data  output  2*DATA_W  read result, held until next rd_valid
addr_err  output  1  one-cycle pulse: request rejected, req_addr ≥ DEPTH

Behaviour:
- Reset (rst=0, asynchronous):
  - busy=0, rd_valid=0, rd_data=0, addr_err=0.
  - FSM goes to IDLE.
  - Memory array is not cleared, unless the optional feature is enabled.
- FSM states: IDLE, WIDE2 (plus CLEAR with the optional feature).
- IDLE, req_valid=1, req_addr ≥ DEPTH:
  - No array access.
  - addr_err=1 next cycle.
  - Stay in IDLE.
- IDLE, narrow read (req_wide=0, req_we=0):
  - Array read at req_addr.
  - Next cycle: rd_data = {DATA_W zeros, mem[addr]}, rd_valid=1.
  - Latency is 1 cycle.
- IDLE, narrow write:
  - mem[addr] ← req_wdata[DATA_W-1:0] on this edge.
  - No rd_valid.
- IDLE, wide request:
  - Beat 1 (accept edge) accesses addr; the FSM latches addr, we and wdata, then moves to WIDE2.
  - busy=1 for exactly the WIDE2 cycle.
  - Beat 2 accesses addr+1. This wraps: addr = DEPTH-1 gives a second beat at 0, with no addr_err.
  - Word order:
    - mem[addr] ↔ [2*DATA_W-1:DATA_W] (high half)
    - mem[addr+1] ↔ [DATA_W-1:0] (low half)
  - Wide write: both halves are taken from the latched wdata, so the requester's bus may change after accept.
  - Wide read: rd_valid=1 one cycle after beat 2, i.e. 2 cycles after accept, with both halves valid together. rd_data does not change between the beats.
- WIDE2 → IDLE unconditionally.
  - req_valid is ignored while busy=1; the requester must hold its request.
- A read following a write to the same address returns the new data.
  - Single port and sequential beats, so no bypass is needed.
  - A wide read of addr immediately after a wide write of addr returns the written value.
- Reset asserted during WIDE2:
  - Beat 2 is aborted (the second word is not written).
  - Beat 1 stays written.
  - No rd_valid.
- rd_valid and addr_err are never high in the same cycle.

Optional Feature:
Macro DMEM_CLEAR_ON_RESET_EN.
- Defined:
  - After rst deasserts, the FSM enters CLEAR and writes 0 to addresses 0..DEPTH-1, one per cycle.
  - busy=1 for exactly DEPTH cycles; requests are ignored during that time.
  - The FSM then enters IDLE.
  - Reset during CLEAR restarts the sweep at address 0 after release.
- Not defined:
  - No CLEAR state; the FSM leaves reset directly into IDLE.
  - busy=0 after reset.
  - Array contents are undefined until written.

Test Plan:
- Narrow write 16'hBEEF at addr 5, then narrow read addr 5 → rd_valid exactly 1 cycle after the read accept, rd_data=32'h0000_BEEF, busy stays 0.
- Wide write 32'h1234_5678 at addr 10, then narrow reads of 10 and 11 → 16'h1234 and 16'h5678; busy high for 1 cycle during the write.
- Wide read at addr DEPTH-1 after narrow writes mem[DEPTH-1]=16'hAAAA and mem[0]=16'h5555 → rd_data=32'hAAAA_5555, rd_valid 2 cycles after accept, addr_err=0.
- Narrow write, DEPTH=2000, addr 2047 → addr_err pulse, no rd_valid; a subsequent read of every other address is unchanged.
- Wide write 32'hCAFE_F00D at addr 20, rst pulsed low during WIDE2 → mem[20]=16'hCAFE, mem[21] retains its prior value; busy/rd_valid/rd_data are 0 during reset.
- With DMEM_CLEAR_ON_RESET_EN, DEPTH=16:
  - After rst release, busy high exactly 16 cycles.
  - A request held during that window is accepted only on the first cycle after busy falls.
  - A read of any address then returns 0.

Source files
------------

// File: rtl/data_mem_wide.sv
`timescale 1ns/1ps
// data_mem_wide: single-port MEM-stage data memory with a registered read,
// two-beat wide (2*DATA_W) accesses that stall the pipeline via busy, and
// out-of-range request detection.
// Optional build macro DMEM_CLEAR_ON_RESET_EN: after reset release the array
// is swept to zero, one word per cycle, while busy is held high.
module data_mem_wide #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 11,
   parameter int DEPTH  = 2048
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   input  logic                req_we,
   input  logic                req_wide,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0] req_wdata,
   output logic                busy,
   output logic                rd_valid,
   output logic [2*DATA_W-1:0] rd_data,
   output logic                addr_err
);

`ifdef DMEM_CLEAR_ON_RESET_EN
   typedef enum logic [1:0] {IDLE, WIDE2, CLEAR} state_t;
   localparam state_t RESET_STATE = CLEAR;
`else
   typedef enum logic [1:0] {IDLE, WIDE2} state_t;
   localparam state_t RESET_STATE = IDLE;
`endif

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] lat_addr;
   logic              lat_we;
   logic [DATA_W-1:0] lat_lo;
   logic [DATA_W-1:0] rd_hi;
   logic [ADDR_W-1:0] addr2;
   logic              addr_ok;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   assign addr_ok   = {1'b0, req_addr} < DEPTH_V;
   // Second beat wraps from the last word back to word 0.
   assign addr2     = (lat_addr == LAST_ADDR) ? '0 : lat_addr + 1'b1;
   assign mem_rdata = mem[mem_addr];

`ifdef DMEM_CLEAR_ON_RESET_EN
   logic [ADDR_W-1:0] clr_addr;

   // Reset parks the FSM in CLEAR; gating with rst keeps busy low while held.
   assign busy = rst && (state != IDLE);

   // Sweep pointer for the post-reset clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                clr_addr <= '0;
      else if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
   end
`else
   assign busy = (state == WIDE2);
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RESET_STATE;
      else      state <= state_nxt;
   end

   // Next state and the single array port's address/write controls.
   always_comb begin
      state_nxt = state;
      mem_we    = 1'b0;
      mem_addr  = req_addr;
      mem_wdata = req_wdata[DATA_W-1:0];
      case (state)
         IDLE: begin
            if (req_valid && addr_ok) begin
               mem_we = req_we;
               if (req_wide) begin
                  state_nxt = WIDE2;
                  mem_wdata = req_wdata[2*DATA_W-1:DATA_W];
               end
            end
         end
         WIDE2: begin
            state_nxt = IDLE;
            mem_addr  = addr2;
            mem_we    = lat_we;
            mem_wdata = lat_lo;
         end
`ifdef DMEM_CLEAR_ON_RESET_EN
         CLEAR: begin
            mem_addr  = clr_addr;
            mem_we    = 1'b1;
            mem_wdata = '0;
            if (clr_addr == LAST_ADDR) state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Array write port; contents are not reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   // Request latching, read result register and status pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid <= 1'b0;
         addr_err <= 1'b0;
         rd_data  <= '0;
         lat_addr <= '0;
         lat_we   <= 1'b0;
         lat_lo   <= '0;
         rd_hi    <= '0;
      end else begin
         rd_valid <= 1'b0;
         addr_err <= 1'b0;
         if (state == IDLE && req_valid) begin
            if (!addr_ok) begin
               addr_err <= 1'b1;
            end else if (req_wide) begin
               lat_addr <= req_addr;
               lat_we   <= req_we;
               lat_lo   <= req_wdata[DATA_W-1:0];
               rd_hi    <= mem_rdata;
            end else if (!req_we) begin
               rd_data  <= {{DATA_W{1'b0}}, mem_rdata};
               rd_valid <= 1'b1;
            end
         end
         // High half was parked in rd_hi so rd_data only moves once.
         if (state == WIDE2 && !lat_we) begin
            rd_data  <= {rd_hi, mem_rdata};
            rd_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_wide.sv
`timescale 1ns/1ps
// Scoreboard bench for data_mem_wide: the driver predicts each response from
// a word-array model and queues it; a negedge monitor pops and compares.
module tb_data_mem_wide;
   localparam int DW = 16;
   localparam int AW = 11;
`ifdef DMEM_CLEAR_ON_RESET_EN
   localparam int DEPTH = 16;
`else
   localparam int DEPTH = 2000;
`endif
   localparam int LOWN  = (DEPTH < 32) ? DEPTH : 32;
   localparam int HIGHB = (DEPTH > 42) ? DEPTH - 10 : 0;
   localparam int RA    = (DEPTH > 32) ? 20 : 4;
   localparam int ASPAN = 2 ** AW;

   logic          clk = 1'b0, rst = 1'b0;
   logic          req_valid = 1'b0, req_we = 1'b0, req_wide = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [2*DW-1:0] req_wdata = '0;
   logic          busy, rd_valid, addr_err;
   logic [2*DW-1:0] rd_data;

   data_mem_wide #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
      .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
      .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit              is_err;
      logic [2*DW-1:0] data;
      int              cyc;
   } exp_t;

   exp_t            sb[$];
   int              errors = 0, checks = 0;
   logic [DW-1:0]   model [DEPTH];
   logic [2*DW-1:0] hold_exp = '0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endfunction

   // Monitor: every rd_valid/addr_err pulse must match the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         hold_exp = '0;
      end else begin
         if (rd_valid && addr_err) check("pulse_exclusive", 1, 0);
         if (rd_valid || addr_err) begin
            if (sb.size() == 0) begin
               check("unexpected_output", {rd_valid, addr_err}, 0);
            end else begin
               e = sb.pop_front();
               check("event_kind", addr_err, e.is_err);
               check("event_cycle", cyc, e.cyc);
               if (!e.is_err) begin
                  check("rd_data", rd_data, e.data);
                  hold_exp = e.data;
               end
            end
         end else begin
            check("rd_data_hold", rd_data, hold_exp);
         end
      end
   end

   task automatic push(input bit is_err, input logic [2*DW-1:0] d, input int c);
      exp_t e;
      e.is_err = is_err;
      e.data   = d;
      e.cyc    = c;
      sb.push_back(e);
   endtask

   // Present one request, predict its effect, and check busy around it.
   task automatic issue(input bit we, input bit wide, input int addr,
                        input logic [2*DW-1:0] wd);
      int acc, a2;
      req_valid = 1'b1; req_we = we; req_wide = wide;
      req_addr  = AW'(addr); req_wdata = wd;
      @(posedge clk); #1;
      acc = cyc;
      req_valid = 1'b0;
      req_wdata = 32'($urandom);
      if (addr >= DEPTH) begin
         push(1'b1, '0, acc);
         check("busy_after_err", busy, 0);
      end else if (!wide) begin
         if (we) model[addr] = wd[DW-1:0];
         else    push(1'b0, {16'h0, model[addr]}, acc);
         check("busy_narrow", busy, 0);
      end else begin
         a2 = (addr == DEPTH - 1) ? 0 : addr + 1;
         if (we) begin
            model[addr] = wd[2*DW-1:DW];
            model[a2]   = wd[DW-1:0];
         end else begin
            push(1'b0, {model[addr], model[a2]}, acc + 1);
         end
         check("busy_wide2", busy, 1);
         if ($urandom_range(0, 1) == 1) begin
            // A request presented while busy must be ignored.
            req_valid = 1'b1; req_we = 1'b1; req_wide = 1'($urandom_range(0, 1));
            req_addr  = AW'(addr); req_wdata = 32'($urandom);
         end
         @(posedge clk); #1;
         req_valid = 1'b0;
         check("busy_after_wide", busy, 0);
      end
   endtask

   task automatic drain();
      for (int g = 0; g < 20 && sb.size() != 0; g++) @(posedge clk);
      repeat (2) @(negedge clk);
      check("scoreboard_drain", sb.size(), 0);
      #1;
   endtask

   initial begin
      int n, k, a;
      bit rw, rwide;

      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_rd_valid", rd_valid, 0);
      check("reset_rd_data", rd_data, 0);
      check("reset_addr_err", addr_err, 0);
      @(negedge clk) rst = 1'b1;

`ifdef DMEM_CLEAR_ON_RESET_EN
      #1;
      n = busy ? 1 : 0;
      req_valid = 1'b1; req_we = 1'b0; req_wide = 1'b0; req_addr = AW'(3);
      for (int g = 0; g < 100 && busy; g++) begin
         @(posedge clk); #1;
         if (busy) n++;
      end
      check("clear_busy_cycles", n, DEPTH);
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      push(1'b0, '0, cyc + 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) issue(1'b0, 1'b0, i, '0);
`endif

      for (int i = 0; i < LOWN; i++) issue(1'b1, 1'b0, i, 32'($urandom));
      for (int i = HIGHB; i < DEPTH; i++) issue(1'b1, 1'b0, i, 32'($urandom));

      issue(1'b1, 1'b0, 5, 32'h0000_BEEF);
      issue(1'b0, 1'b0, 5, '0);
      issue(1'b1, 1'b1, 10, 32'h1234_5678);
      issue(1'b0, 1'b0, 10, '0);
      issue(1'b0, 1'b0, 11, '0);
      issue(1'b1, 1'b0, DEPTH - 1, 32'h0000_AAAA);
      issue(1'b1, 1'b0, 0, 32'h0000_5555);
      issue(1'b0, 1'b1, DEPTH - 1, '0);
      issue(1'b1, 1'b1, 7, 32'($urandom));
      issue(1'b0, 1'b1, 7, '0);
      if (DEPTH < ASPAN) begin
         issue(1'b1, 1'b0, ASPAN - 1, 32'h0000_DEAD);
         for (int i = 0; i < LOWN; i++) issue(1'b0, 1'b0, i, '0);
         for (int i = HIGHB; i < DEPTH; i++) issue(1'b0, 1'b0, i, '0);
      end

      for (int i = 0; i < 300; i++) begin
         k     = $urandom_range(0, 9);
         rwide = 1'($urandom_range(0, 1));
         rw    = 1'($urandom_range(0, 1));
         if (k <= 5)                        a = $urandom_range(0, LOWN - 1 - rwide);
         else if (k <= 7)                   a = $urandom_range(HIGHB, DEPTH - 1 - rwide);
         else if (k == 8 && DEPTH < ASPAN)  a = $urandom_range(DEPTH, ASPAN - 1);
         else                               a = DEPTH - 1;
         issue(rw, rwide, a, 32'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
      drain();

      // Reset landing in the second beat of a wide write.
      req_valid = 1'b1; req_we = 1'b1; req_wide = 1'b1;
      req_addr  = AW'(RA); req_wdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("busy_before_abort", busy, 1);
      rst = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_rd_valid", rd_valid, 0);
      check("abort_rd_data", rd_data, 0);
      @(posedge clk);
      @(negedge clk) rst = 1'b1;
      #1;
`ifdef DMEM_CLEAR_ON_RESET_EN
      for (int g = 0; g < 100 && busy; g++) begin
         @(posedge clk); #1;
      end
      check("clear_done", busy, 0);
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
`else
      model[RA] = 16'hCAFE;
`endif
      issue(1'b0, 1'b0, RA, '0);
      issue(1'b0, 1'b0, RA + 1, '0);
      issue(1'b0, 1'b1, RA, '0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
